// File: rtl/drenador_salidas_pkg.sv
// Shared definitions for the output drain stage: FSM encoding, sizes and small helpers.
// Imported by the round-robin arbiter and by the drain top level.
package drenador_salidas_pkg;

    localparam int DRN_WIDTH = 12;
    localparam int DRN_CNT_W = 8;
    localparam int NUM_CH    = 4;
    localparam int IDX_TOTAL = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } estado_t;

    function automatic logic [NUM_CH-1:0] one_hot(input logic [1:0] ch);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
    endfunction

    // Channel indices are two bits wide, so the increment wraps 3 -> 0 by itself.
    function automatic logic [1:0] siguiente(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/drenador_salidas_arbitro.sv
// Combinational round-robin grant: first non-empty FIFO at or after the pointer.
// Produces the granted channel and a flag telling whether any FIFO has data.
module arbitro_rr
    import drenador_salidas_pkg::*;
(
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [1:0]        ptr,
    output logic [1:0]        grant,
    output logic              any_valid
);

    // Scan from the farthest offset down so the closest candidate wins last.
    always_comb begin
        grant     = ptr;
        any_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!fifo_empty[ptr + 2'(k)]) begin
                grant     = ptr + 2'(k);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drenador_salidas.sv
// Output drain: round-robin pops of four output FIFOs onto a valid/ready link,
// with per-channel and total word counters readable through a req/idx port.
module drenador_salidas
    import drenador_salidas_pkg::*;
#(
    parameter int WIDTH = DRN_WIDTH,
    parameter int CNT_W = DRN_CNT_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              Enable,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [WIDTH-1:0]  data_in_p0,
    input  logic [WIDTH-1:0]  data_in_p1,
    input  logic [WIDTH-1:0]  data_in_p2,
    input  logic [WIDTH-1:0]  data_in_p3,
    output logic [NUM_CH-1:0] pop,
    output logic [WIDTH-1:0]  data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [1:0]        last_ch,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic [CNT_W-1:0]  salida_contador,
    output logic              valid_contador
);

    estado_t          estado;
    estado_t          estado_sig;
    logic [1:0]       ptr;
    logic [1:0]       ptr_arb;
    logic [1:0]       grant;
    logic [1:0]       grant_q;
    logic [1:0]       grant_sig;
    logic             any_valid;
    logic             handshake;
    logic [WIDTH-1:0] data_sel;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] cnt_total;

    assign handshake = (estado == HOLD) && valid_out && ready_in;

    // On the handshake the next grant must already see the advanced pointer.
    assign ptr_arb = (estado == HOLD) ? siguiente(grant_q) : ptr;

    arbitro_rr u_arbitro (
        .fifo_empty (fifo_empty),
        .ptr        (ptr_arb),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    always_comb begin
        estado_sig = estado;
        grant_sig  = grant_q;
        pop        = '0;
        case (estado)
            IDLE: begin
                if (Enable && any_valid) begin
                    estado_sig = POP;
                    grant_sig  = grant;
                end
            end
            POP: begin
                pop        = one_hot(grant_q);
                estado_sig = CAPT;
            end
            CAPT: begin
                estado_sig = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    if (Enable && any_valid) begin
                        estado_sig = POP;
                        grant_sig  = grant;
                    end else begin
                        estado_sig = IDLE;
                    end
                end
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    always_comb begin
        data_sel = data_in_p0;
        case (grant_q)
            2'd1:    data_sel = data_in_p1;
            2'd2:    data_sel = data_in_p2;
            2'd3:    data_sel = data_in_p3;
            default: data_sel = data_in_p0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= IDLE;
            grant_q   <= '0;
            ptr       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_ch   <= '0;
        end else begin
            estado  <= estado_sig;
            grant_q <= grant_sig;
            // FIFO read data is valid the cycle after the pop, i.e. during CAPT.
            if (estado == CAPT) begin
                data_out  <= data_sel;
                last_ch   <= grant_q;
                valid_out <= 1'b1;
            end else if (handshake) begin
                valid_out <= 1'b0;
                ptr       <= siguiente(grant_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n] <= '0;
            end
            cnt_total <= '0;
        end else if (handshake) begin
            cnt[grant_q] <= cnt[grant_q] + CNT_W'(1);
            cnt_total    <= cnt_total + CNT_W'(1);
        end
    end

    // Reads sample the counters before this cycle's increment lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            salida_contador <= '0;
            valid_contador  <= 1'b0;
        end else begin
            valid_contador <= 1'b0;
            if (req) begin
                if (idx < 3'(IDX_TOTAL)) begin
                    salida_contador <= cnt[idx[1:0]];
                    valid_contador  <= 1'b1;
                end else if (idx == 3'(IDX_TOTAL)) begin
                    salida_contador <= cnt_total;
                    valid_contador  <= 1'b1;
                end else begin
                    salida_contador <= '0;
                end
            end
        end
    end

endmodule
